jtag_sb_regs: RTL and testbench

- DMI-side system-bus register block of the debug module; sits directly upstream of the system-bus access engine (jtag_sba).
- Decodes DMI reads/writes to sbcs (0x38), sbaddress0 (0x39) and sbdata0 (0x3C).
- Holds the sbcs control fields, the address register and the data register; issues the one-cycle strobes that start bus reads/writes.
- Absorbs busy/error/data/address results returned by the engine.

---
 rtl/jtag_dm_pkg.sv | 31 +++
 rtl/jtag_sb_regs.sv | 188 ++++++++++++++++++
 tb/tb_jtag_sb_regs.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_dm_pkg.sv
// Shared debug-module constants: DMI register addresses, DMI opcodes, sbcs field positions.
// Latency: n/a (constants only).
// Backpressure: n/a.
package jtag_dm_pkg;

    // DMI register map (system-bus subset)
    localparam logic [6:0] DMI_SBCS       = 7'h38;
    localparam logic [6:0] DMI_SBADDRESS0 = 7'h39;
    localparam logic [6:0] DMI_SBDATA0    = 7'h3C;

    // DMI operations
    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    // sbcs bit positions
    localparam int SBCS_SBVERSION_LSB  = 29;
    localparam int SBCS_SBBUSYERROR    = 22;
    localparam int SBCS_SBBUSY         = 21;
    localparam int SBCS_SBREADONADDR   = 20;
    localparam int SBCS_SBACCESS_LSB   = 17;
    localparam int SBCS_SBAUTOINC      = 16;
    localparam int SBCS_SBREADONDATA   = 15;
    localparam int SBCS_SBERROR_LSB    = 12;
    localparam int SBCS_SBASIZE_LSB    = 5;

    localparam logic [2:0] SBVERSION      = 3'd1;
    localparam logic [2:0] SBACCESS_RESET = 3'd2;   // 32-bit accesses out of reset
    localparam logic [4:0] SBACCESS_CAPS  = 5'b00111; // 8/16/32-bit accesses supported

endpackage

// File: rtl/jtag_sb_regs.sv
// DMI-side system-bus registers (sbcs, sbaddress0, sbdata0); issues start strobes to jtag_sba.
// Latency: response and strobes registered, one cycle after the accepted DMI request.
// Backpressure: none; dmi_req_ready_o tied high, one request accepted per cycle.
//
// Ports:
//   clk/rst                 clock, asynchronous active-high reset
//   dmi_req_*/dmi_op_i/...  DMI request in, one-cycle response pulse out
//   sb*_o                   register values and one-cycle strobes to the bus engine
//   sb*_i                   busy/error/data/address results returned by the engine
module jtag_sb_regs
    import jtag_dm_pkg::*;
#(
    parameter int DMI_ADDR_W = 7,
    parameter int SBASIZE    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dmi_req_valid_i,
    output logic                  dmi_req_ready_o,
    input  logic [1:0]            dmi_op_i,
    input  logic [DMI_ADDR_W-1:0] dmi_addr_i,
    input  logic [31:0]           dmi_wdata_i,
    output logic                  dmi_resp_valid_o,
    output logic [31:0]           dmi_resp_data_o,
    output logic [31:0]           sbaddress_o,
    output logic                  sbaddress_write_valid_o,
    output logic                  sbreadonaddr_o,
    output logic                  sbautoincrement_o,
    output logic [2:0]            sbaccess_o,
    output logic                  sbreadondata_o,
    output logic [31:0]           sbdata_o,
    output logic                  sbdata_read_valid_o,
    output logic                  sbdata_write_valid_o,
    input  logic [31:0]           sbaddress_i,
    input  logic [31:0]           sbdata_i,
    input  logic                  sbdata_valid_i,
    input  logic                  sbbusy_i,
    input  logic [2:0]            sberror_i
);

    localparam logic [DMI_ADDR_W-1:0] ADDR_SBCS  = DMI_ADDR_W'(DMI_SBCS);
    localparam logic [DMI_ADDR_W-1:0] ADDR_SBADR = DMI_ADDR_W'(DMI_SBADDRESS0);
    localparam logic [DMI_ADDR_W-1:0] ADDR_SBDAT = DMI_ADDR_W'(DMI_SBDATA0);
    localparam logic [6:0]            SBASIZE_W7 = 7'(SBASIZE);

    logic [31:0] sbaddress_q, sbaddress_d;
    logic [31:0] sbdata_q, sbdata_d;
    logic        sbreadonaddr_q, sbreadonaddr_d;
    logic [2:0]  sbaccess_q, sbaccess_d;
    logic        sbautoincrement_q, sbautoincrement_d;
    logic        sbreadondata_q, sbreadondata_d;
    logic [2:0]  sberror_q, sberror_d;
    logic        sbbusyerror_q, sbbusyerror_d;
    logic        addr_wr_vld_q, addr_wr_vld_d;
    logic        data_wr_vld_q, data_wr_vld_d;
    logic        data_rd_vld_q, data_rd_vld_d;
    logic        resp_vld_q, resp_vld_d;
    logic [31:0] resp_dat_q, resp_dat_d;

    logic        is_rd, is_wr, blocked, busyerr_set;
    logic [31:0] sbcs_rdata, rdata;

    assign is_rd   = dmi_req_valid_i && (dmi_op_i == DMI_OP_READ);
    assign is_wr   = dmi_req_valid_i && (dmi_op_i == DMI_OP_WRITE);
    // Any outstanding error or a running access suppresses new bus strobes.
    assign blocked = sbbusy_i || sbbusyerror_q || (sberror_q != 3'd0);

    assign sbcs_rdata = {SBVERSION, 6'b0, sbbusyerror_q, sbbusy_i, sbreadonaddr_q, sbaccess_q,
                         sbautoincrement_q, sbreadondata_q, sberror_q, SBASIZE_W7, SBACCESS_CAPS};

    always_comb begin
        sbaddress_d       = sbaddress_q;
        sbdata_d          = sbdata_q;
        sbreadonaddr_d    = sbreadonaddr_q;
        sbaccess_d        = sbaccess_q;
        sbautoincrement_d = sbautoincrement_q;
        sbreadondata_d    = sbreadondata_q;
        sberror_d         = sberror_q;
        sbbusyerror_d     = sbbusyerror_q;
        addr_wr_vld_d     = 1'b0;
        data_wr_vld_d     = 1'b0;
        data_rd_vld_d     = 1'b0;
        resp_vld_d        = dmi_req_valid_i;
        resp_dat_d        = resp_dat_q;
        rdata             = 32'd0;
        busyerr_set       = 1'b0;

        // Engine results; DMI writes below cannot collide because they are refused while busy.
        if (sbbusy_i)       sbaddress_d = sbaddress_i;
        if (sbdata_valid_i) sbdata_d    = sbdata_i;

        if (is_rd) begin
            case (dmi_addr_i)
                ADDR_SBCS:  rdata = sbcs_rdata;
                ADDR_SBADR: rdata = sbaddress_q;
                ADDR_SBDAT: rdata = sbdata_q;
                default:    rdata = 32'd0;
            endcase
            if (dmi_addr_i == ADDR_SBDAT) begin
                if (sbbusy_i)      busyerr_set   = 1'b1;
                else if (!blocked) data_rd_vld_d = 1'b1;
            end
        end

        if (is_wr) begin
            case (dmi_addr_i)
                ADDR_SBCS: begin
                    sbreadonaddr_d    = dmi_wdata_i[SBCS_SBREADONADDR];
                    sbaccess_d        = dmi_wdata_i[SBCS_SBACCESS_LSB +: 3];
                    sbautoincrement_d = dmi_wdata_i[SBCS_SBAUTOINC];
                    sbreadondata_d    = dmi_wdata_i[SBCS_SBREADONDATA];
                    sberror_d         = sberror_q & ~dmi_wdata_i[SBCS_SBERROR_LSB +: 3];
                    if (dmi_wdata_i[SBCS_SBBUSYERROR]) sbbusyerror_d = 1'b0;
                end
                ADDR_SBADR: begin
                    if (sbbusy_i) begin
                        busyerr_set = 1'b1;
                    end else begin
                        sbaddress_d   = dmi_wdata_i;
                        addr_wr_vld_d = !blocked;
                    end
                end
                ADDR_SBDAT: begin
                    if (sbbusy_i) begin
                        busyerr_set = 1'b1;
                    end else begin
                        sbdata_d      = dmi_wdata_i;
                        data_wr_vld_d = !blocked;
                    end
                end
                default: ;
            endcase
        end

        // Set beats W1C clear for both error fields. The engine error is judged against
        // the post-clear value so a clear and a fresh error in one cycle keeps the new one.
        if (busyerr_set) sbbusyerror_d = 1'b1;
        if ((sberror_i != 3'd0) && (sberror_d == 3'd0)) sberror_d = sberror_i;

        if (dmi_req_valid_i) resp_dat_d = rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbaddress_q       <= 32'd0;
            sbdata_q          <= 32'd0;
            sbreadonaddr_q    <= 1'b0;
            sbaccess_q        <= SBACCESS_RESET;
            sbautoincrement_q <= 1'b0;
            sbreadondata_q    <= 1'b0;
            sberror_q         <= 3'd0;
            sbbusyerror_q     <= 1'b0;
            addr_wr_vld_q     <= 1'b0;
            data_wr_vld_q     <= 1'b0;
            data_rd_vld_q     <= 1'b0;
            resp_vld_q        <= 1'b0;
            resp_dat_q        <= 32'd0;
        end else begin
            sbaddress_q       <= sbaddress_d;
            sbdata_q          <= sbdata_d;
            sbreadonaddr_q    <= sbreadonaddr_d;
            sbaccess_q        <= sbaccess_d;
            sbautoincrement_q <= sbautoincrement_d;
            sbreadondata_q    <= sbreadondata_d;
            sberror_q         <= sberror_d;
            sbbusyerror_q     <= sbbusyerror_d;
            addr_wr_vld_q     <= addr_wr_vld_d;
            data_wr_vld_q     <= data_wr_vld_d;
            data_rd_vld_q     <= data_rd_vld_d;
            resp_vld_q        <= resp_vld_d;
            resp_dat_q        <= resp_dat_d;
        end
    end

    assign dmi_req_ready_o         = 1'b1;
    assign dmi_resp_valid_o        = resp_vld_q;
    assign dmi_resp_data_o         = resp_dat_q;
    assign sbaddress_o             = sbaddress_q;
    assign sbaddress_write_valid_o = addr_wr_vld_q;
    assign sbreadonaddr_o          = sbreadonaddr_q;
    assign sbautoincrement_o       = sbautoincrement_q;
    assign sbaccess_o              = sbaccess_q;
    assign sbreadondata_o          = sbreadondata_q;
    assign sbdata_o                = sbdata_q;
    assign sbdata_read_valid_o     = data_rd_vld_q;
    assign sbdata_write_valid_o    = data_wr_vld_q;

endmodule

// File: tb/tb_jtag_sb_regs.sv
// Self-checking bench for jtag_sb_regs: directed scenarios plus randomized DMI/engine traffic
// compared against a register-level reference model.
// Runs a few hundred cycles; terminates on its own.
module tb_jtag_sb_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmi_req_valid_i;
    logic        dmi_req_ready_o;
    logic [1:0]  dmi_op_i;
    logic [6:0]  dmi_addr_i;
    logic [31:0] dmi_wdata_i;
    logic        dmi_resp_valid_o;
    logic [31:0] dmi_resp_data_o;
    logic [31:0] sbaddress_o;
    logic        sbaddress_write_valid_o;
    logic        sbreadonaddr_o;
    logic        sbautoincrement_o;
    logic [2:0]  sbaccess_o;
    logic        sbreadondata_o;
    logic [31:0] sbdata_o;
    logic        sbdata_read_valid_o;
    logic        sbdata_write_valid_o;
    logic [31:0] sbaddress_i;
    logic [31:0] sbdata_i;
    logic        sbdata_valid_i;
    logic        sbbusy_i;
    logic [2:0]  sberror_i;

    always #5 clk = ~clk;

    jtag_sb_regs #(.DMI_ADDR_W(7), .SBASIZE(32)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .dmi_req_valid_i         (dmi_req_valid_i),
        .dmi_req_ready_o         (dmi_req_ready_o),
        .dmi_op_i                (dmi_op_i),
        .dmi_addr_i              (dmi_addr_i),
        .dmi_wdata_i             (dmi_wdata_i),
        .dmi_resp_valid_o        (dmi_resp_valid_o),
        .dmi_resp_data_o         (dmi_resp_data_o),
        .sbaddress_o             (sbaddress_o),
        .sbaddress_write_valid_o (sbaddress_write_valid_o),
        .sbreadonaddr_o          (sbreadonaddr_o),
        .sbautoincrement_o       (sbautoincrement_o),
        .sbaccess_o              (sbaccess_o),
        .sbreadondata_o          (sbreadondata_o),
        .sbdata_o                (sbdata_o),
        .sbdata_read_valid_o     (sbdata_read_valid_o),
        .sbdata_write_valid_o    (sbdata_write_valid_o),
        .sbaddress_i             (sbaddress_i),
        .sbdata_i                (sbdata_i),
        .sbdata_valid_i          (sbdata_valid_i),
        .sbbusy_i                (sbbusy_i),
        .sberror_i               (sberror_i)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: architectural register contents only.
    logic [31:0] m_addr, m_data;
    logic [2:0]  m_access, m_err;
    logic        m_roa, m_ai, m_rod, m_be;

    task automatic model_reset();
        m_addr = 0; m_data = 0; m_access = 3'd2; m_err = 0;
        m_roa = 0; m_ai = 0; m_rod = 0; m_be = 0;
    endtask

    // sbcs as seen by the debugger, built from field values and bit weights.
    function automatic logic [31:0] model_sbcs(input logic busy);
        int unsigned v;
        v = (1 << 29) + (int'(m_be) << 22) + (int'(busy) << 21) + (int'(m_roa) << 20)
          + (int'(m_access) << 17) + (int'(m_ai) << 16) + (int'(m_rod) << 15)
          + (int'(m_err) << 12) + (32 << 5) + 7;
        return v;
    endfunction

    task automatic check_regs(input string pfx);
        chk({pfx, "_sbaddress"}, sbaddress_o, m_addr);
        chk({pfx, "_sbdata"}, sbdata_o, m_data);
        chk({pfx, "_ctl"}, {27'd0, sbreadonaddr_o, sbautoincrement_o, sbreadondata_o, sbaccess_o},
            {27'd0, m_roa, m_ai, m_rod, m_access});
    endtask

    task automatic drive_idle();
        dmi_req_valid_i = 0; dmi_op_i = 0; dmi_addr_i = 0; dmi_wdata_i = 0;
        sbaddress_i = 0; sbdata_i = 0; sbdata_valid_i = 0; sbbusy_i = 0; sberror_i = 0;
    endtask

    // One clock of stimulus; the model predicts the registered outputs seen after the edge.
    task automatic step(input logic v, input logic [1:0] op, input logic [6:0] a,
                        input logic [31:0] wd, input logic busy = 1'b0, input logic dv = 1'b0,
                        input logic [31:0] sd = 32'd0, input logic [2:0] se = 3'd0,
                        input logic [31:0] sa = 32'd0);
        logic        blocked, rd, wr, set_be, e_aw, e_dw, e_dr;
        logic [31:0] e_rd;
        dmi_req_valid_i = v; dmi_op_i = op; dmi_addr_i = a; dmi_wdata_i = wd;
        sbbusy_i = busy; sbdata_valid_i = dv; sbdata_i = sd; sberror_i = se; sbaddress_i = sa;

        blocked = busy || m_be || (m_err != 0);
        rd = v && (op == 2'd1);
        wr = v && (op == 2'd2);
        e_rd = 0; e_aw = 0; e_dw = 0; e_dr = 0; set_be = 0;
        if (rd) begin
            if (a == 7'h38) e_rd = model_sbcs(busy);
            else if (a == 7'h39) e_rd = m_addr;
            else if (a == 7'h3C) e_rd = m_data;
        end
        if (busy) m_addr = sa;
        if (dv) m_data = sd;
        if (wr && a == 7'h38) begin
            m_roa    = ((wd >> 20) & 1) != 0;
            m_access = 3'((wd >> 17) & 7);
            m_ai     = ((wd >> 16) & 1) != 0;
            m_rod    = ((wd >> 15) & 1) != 0;
            m_err    = m_err & ~3'((wd >> 12) & 7);
            if (((wd >> 22) & 1) != 0) m_be = 0;
        end
        if (wr && a == 7'h39) begin
            if (busy) set_be = 1;
            else begin m_addr = wd; e_aw = !blocked; end
        end
        if (wr && a == 7'h3C) begin
            if (busy) set_be = 1;
            else begin m_data = wd; e_dw = !blocked; end
        end
        if (rd && a == 7'h3C) begin
            if (busy) set_be = 1;
            else e_dr = !blocked;
        end
        if (set_be) m_be = 1;
        if (se != 0 && m_err == 0) m_err = se;

        @(posedge clk);
        #1;
        chk("resp_valid", 32'(dmi_resp_valid_o), 32'(v));
        if (v) chk("resp_data", dmi_resp_data_o, e_rd);
        chk("strobes", {29'd0, sbaddress_write_valid_o, sbdata_write_valid_o, sbdata_read_valid_o},
            {29'd0, e_aw, e_dw, e_dr});
        chk("req_ready", 32'(dmi_req_ready_o), 32'd1);
        check_regs("step");
    endtask

    // Reset raised between edges must clear state without waiting for a clock.
    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        #1;
        model_reset();
        chk("rst_strobes", {29'd0, sbaddress_write_valid_o, sbdata_write_valid_o, sbdata_read_valid_o}, 32'd0);
        chk("rst_resp_valid", 32'(dmi_resp_valid_o), 32'd0);
        chk("rst_resp_data", dmi_resp_data_o, 32'd0);
        check_regs("rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    localparam logic [1:0] RD = 2'd1;
    localparam logic [1:0] WR = 2'd2;

    initial begin
        logic [31:0] base;
        drive_idle();
        rst = 1'b0;
        #2;
        do_reset();

        // Reset value of sbcs
        step(1, RD, 7'h38, 0);
        chk("sbcs_reset", dmi_resp_data_o, 32'h2004_0407);

        // Read-on-address setup, address write strobe, engine read data return
        step(1, WR, 7'h38, (1 << 20) | (2 << 17));
        step(1, WR, 7'h39, 32'h2000_0000);
        chk("addr_strobe", 32'(sbaddress_write_valid_o), 32'd1);
        chk("addr_value", sbaddress_o, 32'h2000_0000);
        step(0, 0, 0, 0, 1, 0, 0, 0, 32'h2000_0000);
        step(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        step(1, RD, 7'h3C, 0);
        chk("rd_data_return", dmi_resp_data_o, 32'hDEAD_BEEF);

        // Autoincrement captured from the engine while busy
        step(1, WR, 7'h38, (1 << 20) | (2 << 17) | (1 << 16));
        step(0, 0, 0, 0, 1, 0, 0, 0, 32'h2000_0004);
        step(0, 0, 0, 0);
        step(1, RD, 7'h39, 0);
        chk("autoinc_addr", dmi_resp_data_o, 32'h2000_0004);

        // Busy error: refused write, then blocked address write, then W1C
        step(1, WR, 7'h3C, 32'h1234_5678, 1, 0, 0, 0, 32'h2000_0004);
        chk("busy_no_strobe", 32'(sbdata_write_valid_o), 32'd0);
        step(1, WR, 7'h39, 32'h2000_0100);
        chk("busyerr_blocks_addr", 32'(sbaddress_write_valid_o), 32'd0);
        step(1, RD, 7'h38, 0);
        chk("busyerr_set", (dmi_resp_data_o >> 22) & 1, 32'd1);
        step(1, WR, 7'h38, (1 << 22) | (2 << 17));
        step(1, RD, 7'h38, 0);
        chk("busyerr_clr", (dmi_resp_data_o >> 22) & 1, 32'd0);

        // Engine error: sticky, blocks strobes; set beats same-cycle clear
        step(0, 0, 0, 0, 0, 0, 0, 3'd3);
        step(1, RD, 7'h38, 0);
        chk("sberror_3", (dmi_resp_data_o >> 12) & 7, 32'd3);
        step(1, WR, 7'h3C, 32'hA5A5_0001);
        chk("err_blocks_data", 32'(sbdata_write_valid_o), 32'd0);
        step(1, WR, 7'h38, (7 << 12) | (2 << 17), 0, 0, 0, 3'd2);
        step(1, RD, 7'h38, 0);
        chk("sberror_set_wins", (dmi_resp_data_o >> 12) & 7, 32'd2);
        step(1, WR, 7'h38, (7 << 12) | (2 << 17));

        // Read-on-data: old data returned, single read strobe
        step(1, WR, 7'h38, (1 << 15) | (2 << 17));
        base = m_data;
        step(1, RD, 7'h3C, 0);
        chk("rod_old_data", dmi_resp_data_o, base);
        chk("rod_strobe", 32'(sbdata_read_valid_o), 32'd1);
        step(0, 0, 0, 0);
        chk("rod_strobe_once", 32'(sbdata_read_valid_o), 32'd0);

        // Reset in the cycle a strobe is showing
        step(1, WR, 7'h39, 32'h3000_0000);
        chk("pre_rst_strobe", 32'(sbaddress_write_valid_o), 32'd1);
        #2;
        do_reset();
        step(1, RD, 7'h38, 0);
        chk("sbcs_after_rst", dmi_resp_data_o, 32'h2004_0407);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [6:0]  a;
            logic [1:0]  op;
            logic [31:0] wd;
            logic        busy;
            case ($urandom_range(0, 3))
                0: a = 7'h38;
                1: a = 7'h39;
                2: a = 7'h3C;
                default: a = 7'($urandom);
            endcase
            op = 2'($urandom);
            wd = $urandom;
            // Keep error fields mostly clear so strobes get exercised.
            if (a == 7'h38 && $urandom_range(0, 3) != 0) wd = wd | (32'h7 << 12) | (32'h1 << 22);
            busy = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2;
                do_reset();
            end else begin
                step($urandom_range(0, 4) != 0, op, a, wd, busy,
                     $urandom_range(0, 5) == 0, $urandom,
                     ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
                     $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
